// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped console FIFOs, cycle counter and stop flag; read data 1 cycle after request.
// TX backpressure via tx_valid/tx_ready; io_buffer_full warns the cpu early. Optional MEM_IO_BOUNDS_CHECK_EN adds bus_err.
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 16,
    parameter int RX_DEPTH       = 16,
    parameter int FULL_MARGIN    = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_done
`ifdef MEM_IO_BOUNDS_CHECK_EN
    ,
    output logic        bus_err
`endif
);
    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam logic [TXW:0] TX_FULL_CNT = (TXW+1)'(TX_DEPTH);
    localparam logic [TXW:0] TX_THRESH   = (TXW+1)'(TX_DEPTH - FULL_MARGIN);
    localparam logic [RXW:0] RX_FULL_CNT = (RXW+1)'(RX_DEPTH);

    logic                      is_io;
    logic                      oob;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic [15:0]               io_off;
    logic [7:0]                ram [2**RAM_ADDR_WIDTH];
    logic [31:0]               counter;
    logic [23:0]               snap;
    logic [7:0]                rdata_nxt;

    assign is_io   = (cpu_a[17:16] == 2'b11);
    assign ram_idx = cpu_a[RAM_ADDR_WIDTH-1:0];
    assign io_off  = cpu_a[15:0];

`ifdef MEM_IO_BOUNDS_CHECK_EN
    assign oob = !is_io && (cpu_a[31:RAM_ADDR_WIDTH] != '0);
    always_ff @(posedge clk_in) begin
        if (rst_in)   bus_err <= 1'b0;
        else if (oob) bus_err <= 1'b1;
    end
`else
    logic unused_addr_hi;
    assign oob            = 1'b0;
    assign unused_addr_hi = ^cpu_a[31:18];
`endif

    always_ff @(posedge clk_in) begin
        if (!is_io && cpu_wr && !oob) ram[ram_idx] <= cpu_wdata;
    end

    // TX FIFO: cpu pushes, UART pops
    logic [7:0]   tx_mem [TX_DEPTH];
    logic [TXW-1:0] tx_rd, tx_wr;
    logic [TXW:0] tx_count, tx_count_nxt;
    logic         tx_pop, tx_push, tx_push_req;
    logic [7:0]   tx_push_dat;

    assign tx_valid    = (tx_count != '0);
    assign tx_data     = tx_mem[tx_rd];
    assign tx_pop      = tx_valid && tx_ready;
    assign tx_push_req = is_io && cpu_wr &&
                         (((io_off == 16'h0000) && (cpu_wdata != 8'h00)) || (io_off == 16'h0004));
    assign tx_push_dat = (io_off == 16'h0004) ? 8'h00 : cpu_wdata;
    assign tx_push     = tx_push_req && ((tx_count != TX_FULL_CNT) || tx_pop);

    always_comb begin
        tx_count_nxt = tx_count;
        if (tx_push && !tx_pop)      tx_count_nxt = tx_count + (TXW+1)'(1);
        else if (!tx_push && tx_pop) tx_count_nxt = tx_count - (TXW+1)'(1);
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wr] <= tx_push_dat;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_rd          <= '0;
            tx_wr          <= '0;
            tx_count       <= '0;
            io_buffer_full <= 1'b0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + TXW'(1);
            if (tx_pop)  tx_rd <= tx_rd + TXW'(1);
            tx_count       <= tx_count_nxt;
            io_buffer_full <= (tx_count_nxt >= TX_THRESH);
        end
    end

    // RX FIFO: UART pushes, cpu pops; no bypass, so an empty read returns 0 even with rx_valid high
    logic [7:0]   rx_mem [RX_DEPTH];
    logic [RXW-1:0] rx_rd, rx_wr;
    logic [RXW:0] rx_count;
    logic         rx_pop, rx_push;

    assign rx_pop  = is_io && !cpu_wr && (io_off == 16'h0000) && (rx_count != '0);
    assign rx_push = rx_valid && (rx_count != RX_FULL_CNT);

    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wr] <= rx_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_rd    <= '0;
            rx_wr    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + RXW'(1);
            if (rx_pop)  rx_rd <= rx_rd + RXW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + (RXW+1)'(1);
            else if (!rx_push && rx_pop) rx_count <= rx_count - (RXW+1)'(1);
        end
    end

    always_comb begin
        rdata_nxt = 8'h00;
        if (!cpu_wr) begin
            if (is_io) begin
                case (io_off)
                    16'h0000: rdata_nxt = rx_pop ? rx_mem[rx_rd] : 8'h00;
                    16'h0004: rdata_nxt = counter[7:0];
                    16'h0005: rdata_nxt = snap[7:0];
                    16'h0006: rdata_nxt = snap[15:8];
                    16'h0007: rdata_nxt = snap[23:16];
                    default:  rdata_nxt = 8'h00;
                endcase
            end else if (!oob) begin
                rdata_nxt = ram[ram_idx];
            end
        end
    end

    // Reading the low counter byte freezes the upper bytes so a 4-byte read sequence is coherent
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cpu_rdata    <= 8'h00;
            counter      <= 32'd0;
            snap         <= 24'd0;
            program_done <= 1'b0;
        end else begin
            cpu_rdata <= rdata_nxt;
            counter   <= counter + 32'd1;
            if (is_io && !cpu_wr && (io_off == 16'h0004)) snap <= counter[31:8];
            if (is_io && cpu_wr && (io_off == 16'h0004))  program_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX/RX FIFOs, counter snapshot, stop flag and reset.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] cpu_a = 32'h100;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        program_done;
`ifdef MEM_IO_BOUNDS_CHECK_EN
    logic        bus_err;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .program_done(program_done)
`ifdef MEM_IO_BOUNDS_CHECK_EN
        , .bus_err(bus_err)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic wr, input logic [7:0] d);
        cpu_a = a; cpu_wr = wr; cpu_wdata = d;
        cyc();
    endtask

    task automatic do_reset();
        rst_in = 1'b1; cpu_a = 32'h100; cpu_wr = 1'b0;
        cyc();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got %h want 00", cpu_rdata); end
        n_cmp++; if ({tx_valid, io_buffer_full, program_done} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags got %b want 000", {tx_valid, io_buffer_full, program_done}); end
        req(32'h30000, 1'b0, 8'h00);
        n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rx_empty got %h want 00", cpu_rdata); end
    endtask

    task automatic test_ram();
        req(32'h00010, 1'b1, 8'hA5);
        req(32'h00010, 1'b0, 8'h00);
        n_cmp++; if (cpu_rdata !== 8'hA5) begin n_bad++; $display("FAIL ram_raw got %h want a5", cpu_rdata); end
        req(32'h1FFFF, 1'b1, 8'h5A);
        req(32'h00000, 1'b1, 8'hC3);
        req(32'h1FFFF, 1'b0, 8'h00);
        n_cmp++; if (cpu_rdata !== 8'h5A) begin n_bad++; $display("FAIL ram_top got %h want 5a", cpu_rdata); end
        req(32'h00000, 1'b0, 8'h00);
        n_cmp++; if (cpu_rdata !== 8'hC3) begin n_bad++; $display("FAIL ram_bottom got %h want c3", cpu_rdata); end
        req(32'h20010, 1'b1, 8'h99);
        req(32'h00010, 1'b0, 8'h00);
`ifdef MEM_IO_BOUNDS_CHECK_EN
        n_cmp++; if (cpu_rdata !== 8'hA5) begin n_bad++; $display("FAIL ram_oob_wr got %h want a5", cpu_rdata); end
        n_cmp++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL bus_err got %b want 1", bus_err); end
`else
        n_cmp++; if (cpu_rdata !== 8'h99) begin n_bad++; $display("FAIL ram_alias got %h want 99", cpu_rdata); end
`endif
    endtask

    task automatic test_tx_filter();
        tx_ready = 1'b1;
        req(32'h30000, 1'b1, 8'h41);
        n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'h41}) begin
            n_bad++; $display("FAIL tx_first got %b/%h want 1/41", tx_valid, tx_data); end
        req(32'h30000, 1'b1, 8'h00);
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_zero_skip got %b want 0", tx_valid); end
        req(32'h30000, 1'b1, 8'h42);
        n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'h42}) begin
            n_bad++; $display("FAIL tx_second got %b/%h want 1/42", tx_valid, tx_data); end
        req(32'h100, 1'b0, 8'h00);
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_drained got %b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_tx_full();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 1; i <= 28; i++) begin
            req(32'h30000, 1'b1, 8'(i));
            if (i == 11) begin
                n_cmp++; if (io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL full_at_11 got %b want 0", io_buffer_full); end
            end
            if (i == 12) begin
                n_cmp++; if (io_buffer_full !== 1'b1) begin n_bad++; $display("FAIL full_at_12 got %b want 1", io_buffer_full); end
            end
        end
        n_cmp++; if (io_buffer_full !== 1'b1) begin n_bad++; $display("FAIL full_at_16 got %b want 1", io_buffer_full); end
        cpu_a = 32'h100; cpu_wr = 1'b0; tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'(i)}) begin
                n_bad++; $display("FAIL tx_drain_%0d got %b/%h want 1/%h", i, tx_valid, tx_data, 8'(i)); end
            cyc();
        end
        n_cmp++; if ({tx_valid, io_buffer_full} !== 2'b00) begin
            n_bad++; $display("FAIL tx_after_drain got %b want 00", {tx_valid, io_buffer_full}); end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx();
        cpu_a = 32'h100; cpu_wr = 1'b0;
        rx_valid = 1'b1; rx_data = 8'h31; cyc();
        rx_data = 8'h32; cyc();
        rx_valid = 1'b0;
        req(32'h30000, 1'b0, 8'h00);
        n_cmp++; if (cpu_rdata !== 8'h31) begin n_bad++; $display("FAIL rx_pop1 got %h want 31", cpu_rdata); end
        req(32'h30000, 1'b0, 8'h00);
        n_cmp++; if (cpu_rdata !== 8'h32) begin n_bad++; $display("FAIL rx_pop2 got %h want 32", cpu_rdata); end
        req(32'h30000, 1'b0, 8'h00);
        n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL rx_empty got %h want 00", cpu_rdata); end
        rx_valid = 1'b1; rx_data = 8'h55;
        req(32'h30000, 1'b0, 8'h00);
        rx_valid = 1'b0;
        n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL rx_no_bypass got %h want 00", cpu_rdata); end
        req(32'h30000, 1'b0, 8'h00);
        n_cmp++; if (cpu_rdata !== 8'h55) begin n_bad++; $display("FAIL rx_after_bypass got %h want 55", cpu_rdata); end
        req(32'h30008, 1'b0, 8'h00);
        n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL io_other_rd got %h want 00", cpu_rdata); end
    endtask

    task automatic test_counter_snapshot();
        logic [7:0] exp [6];
        exp[0] = 8'hFF; exp[1] = 8'h00; exp[2] = 8'h00; exp[3] = 8'h00; exp[4] = 8'h03; exp[5] = 8'h01;
        do_reset();
        repeat (255) cyc();
        for (int i = 0; i < 6; i++) begin
            req(32'h30004 + 32'(i % 4), 1'b0, 8'h00);
            n_cmp++; if (cpu_rdata !== exp[i]) begin
                n_bad++; $display("FAIL counter_byte_%0d got %h want %h", i, cpu_rdata, exp[i]); end
        end
    endtask

    task automatic test_done_and_reset();
        cpu_a = 32'h100; cpu_wr = 1'b0; tx_ready = 1'b0;
        req(32'h30004, 1'b1, 8'h7E);
        n_cmp++; if ({program_done, tx_valid, tx_data} !== {2'b11, 8'h00}) begin
            n_bad++; $display("FAIL done_set got %b/%b/%h want 1/1/00", program_done, tx_valid, tx_data); end
        req(32'h100, 1'b0, 8'h00);
        n_cmp++; if (program_done !== 1'b1) begin n_bad++; $display("FAIL done_sticky got %b want 1", program_done); end
        req(32'h00040, 1'b1, 8'h77);
        rst_in = 1'b1;
        req(32'h00040, 1'b0, 8'h00);
        rst_in = 1'b0;
        n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_inflight got %h want 00", cpu_rdata); end
        n_cmp++; if ({program_done, tx_valid, io_buffer_full} !== 3'b000) begin
            n_bad++; $display("FAIL rst_flags got %b want 000", {program_done, tx_valid, io_buffer_full}); end
        req(32'h00040, 1'b0, 8'h00);
        n_cmp++; if (cpu_rdata !== 8'h77) begin n_bad++; $display("FAIL ram_kept got %h want 77", cpu_rdata); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tx_filter();
        test_tx_full();
        test_rx();
        test_counter_snapshot();
        test_done_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
